piso: RTL and testbench
=======================

// Module: piso
// PURPOSE
//   Parallel-in serial-out converter; the transmit-side counterpart of sipo.
//   Accepts one depth_p-element parallel word over a valid/ready handshake.
//   Emits it one width_p-bit element per accepted beat, element 0 (LSB) first.
//   A sipo of matching width_p/depth_p, fed by this block, reassembles the
//   original word bit-exact. Sits between the array result path and narrow
//   serial links/test ports.
// PARAMETERS
//   width_p  1  bits per serial element
//   depth_p  8  elements per parallel word (>=2)
// PORTS
//   clk_i    in   1                single clock, all state on posedge
//   reset_i  in   1                asynchronous, active-low reset
//   valid_i  in   1                parallel word on data_i is valid
//   ready_o  out  1                block can accept a parallel word
//   data_i   in   width_p*depth_p  parallel word; element k = data_i[k*width_p +: width_p]
//   valid_o  out  1                data_o holds a valid serial element
//   ready_i  in   1                downstream consumes data_o this cycle
//   data_o   out  width_p          current serial element
// BEHAVIOUR
//   - Reset (reset_i low, async assert, sync-to-clk release):
//     state=EMPTY, count=0, shift reg=0, valid_o=0, data_o=0.
//     ready_o=0 while reset_i is low.
//   - Handshakes:
//     accept on posedge when valid_i & ready_o;
//     beat consumed on posedge when valid_o & ready_i.
//   - States:
//     EMPTY: valid_o=0, ready_o=1.
//       Accept -> load shift reg with data_i, count=0, go SEND.
//     SEND: valid_o=1, data_o = shift reg[width_p-1:0] (registered, no comb path from data_i).
//       Consumed & count<depth_p-1 -> shift right by width_p, count++.
//       Consumed & count==depth_p-1 (last beat) -> go EMPTY, unless a new
//         word is accepted the same cycle; then reload, count=0, stay SEND.
//   - ready_o = (state==EMPTY) | (state==SEND & count==depth_p-1 & ready_i).
//     This is the only comb path (ready_i->ready_o) and gives zero-bubble
//     back-to-back words.
//   - Latency: first element valid the cycle after accept.
//     Throughput is one element per cycle while ready_i=1; depth_p cycles per word.
//   - Backpressure: ready_i=0 in SEND holds data_o, valid_o and count unchanged.
//     No element is dropped or duplicated.
//   - valid_i while busy (ready_o=0) is ignored; upstream holds data_i stable until accepted.
//   - data_i changing after accept has no effect on the word in flight.
//   - count width $clog2(depth_p); never exceeds depth_p-1, no wrap.
//   - reset_i low mid-word: word discarded immediately, outputs to reset values.
//     After release the block is EMPTY and accepts a fresh word.
// TESTING (width_p=1, depth_p=8, 10ns clk)
//   1 Reset: hold reset_i low 10 cycles -> valid_o=0, ready_o=0, data_o=0.
//     After release ready_o=1.
//   2 Single word: data_i=8'b10000101, valid_i 1 cycle, ready_i=1
//     -> data_o = 1,0,1,0,0,0,0,1 on 8 consecutive cycles with valid_o=1;
//     then valid_o=0, ready_o=1.
//   3 Backpressure: as 2, drop ready_i for 3 cycles after beat 2
//     -> data_o stays 1 (element 2) with valid_o=1; resumes 0,0,0,0,1.
//     Exactly 8 beats consumed.
//   4 Back-to-back: 8'b10000101 then 8'hF0 presented during last beat
//     -> accepted that cycle; 16 contiguous beats 1,0,1,0,0,0,0,1,0,0,0,0,1,1,1,1, no gap.
//   5 Mid-word reset: assert reset_i after beat 3 -> valid_o=0 asynchronously.
//     After release, send 8'h3C -> beats 0,0,1,1,1,1,0,0.
//   6 Loopback: piso->sipo (width_p=1, depth_p=8), send 8'b10000101
//     -> sipo data_o==8'b10000101 after 8 beats.

Source files
------------

// File: rtl/piso.sv
// Parallel-in serial-out: takes a depth_p-element word, emits width_p-bit elements, element 0 first.
// Latency: first element valid the cycle after accept; one element per cycle, depth_p cycles per word.
// Backpressure: ready_i low holds data_o/valid_o/count; ready_o asserts during the last consumed beat.
module piso #(
  parameter int width_p = 1,
  parameter int depth_p = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [width_p*depth_p-1:0] data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [width_p-1:0]         data_o
);

  localparam int cnt_w = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam logic [cnt_w-1:0] last_c = cnt_w'(depth_p - 1);

  typedef enum logic {EMPTY, SEND} state_t;

  state_t                     state_r, state_n;
  logic [cnt_w-1:0]           count_r;
  logic [width_p*depth_p-1:0] shreg_r;
  logic                       accept, consume, last_beat;

  assign accept    = valid_i & ready_o;
  assign consume   = valid_o & ready_i;
  assign last_beat = (count_r == last_c);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_r <= EMPTY;
    else          state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      EMPTY: if (accept) state_n = SEND;
      SEND:  if (consume && last_beat && !accept) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  // ready_i -> ready_o is the only combinational path; it lets a new word
  // load in the same cycle the last beat leaves, with no bubble.
  always_comb begin
    valid_o = (state_r == SEND);
    ready_o = reset_i & ((state_r == EMPTY) |
                         ((state_r == SEND) & last_beat & ready_i));
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_r <= '0;
      shreg_r <= '0;
    end else if (accept) begin
      count_r <= '0;
      shreg_r <= data_i;
    end else if (consume && !last_beat) begin
      count_r <= count_r + 1'b1;
      shreg_r <= shreg_r >> width_p;
    end
  end

  assign data_o = shreg_r[width_p-1:0];

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso (width_p=1, depth_p=8); serial beats are reassembled LSB-first for loopback.
module tb_piso;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_i = '0;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [0:0] data_o;

  int n_cmp = 0;
  int n_err = 0;

  piso #(.width_p(1), .depth_p(8)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a word for one cycle from EMPTY; afterwards element 0 is on data_o.
  task automatic load(input logic [7:0] word);
    data_i  = word;
    valid_i = 1'b1;
    ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    data_i  = ~word;
  endtask

  task automatic test_reset();
    #2 reset_i = 1'b0;
    repeat (10) step();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready_o); end
    n_cmp++; if (data_o !== 1'b0) begin n_err++; $display("FAIL reset_data got %b want 0", data_o); end
    reset_i = 1'b1;
    step();
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL release_ready got %b want 1", ready_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL release_valid got %b want 0", valid_o); end
  endtask

  task automatic test_single();
    logic [7:0] exp;
    exp = 8'b10000101;
    load(exp);
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d] got %b want 1", k, valid_o); end
      n_cmp++; if (data_o !== exp[k]) begin n_err++; $display("FAIL single_data[%0d] got %b want %b", k, data_o, exp[k]); end
      step();
    end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL single_done_valid got %b want 0", valid_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL single_done_ready got %b want 1", ready_o); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    int beats;
    exp = 8'b10000101;
    beats = 0;
    load(exp);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        ready_i = 1'b0;
        repeat (3) begin
          step();
          n_cmp++; if (valid_o !== 1'b1 || data_o !== 1'b1) begin
            n_err++; $display("FAIL bp_hold got valid=%b data=%b want valid=1 data=1", valid_o, data_o);
          end
        end
        ready_i = 1'b1;
      end
      n_cmp++; if (data_o !== exp[k]) begin n_err++; $display("FAIL bp_data[%0d] got %b want %b", k, data_o, exp[k]); end
      if (valid_o && ready_i) beats++;
      step();
    end
    n_cmp++; if (beats !== 8) begin n_err++; $display("FAIL bp_beats got %0d want 8", beats); end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL bp_done_valid got %b want 0", valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    exp = {8'hF0, 8'b10000101};
    load(8'b10000101);
    for (int k = 0; k < 16; k++) begin
      if (k == 7) begin
        data_i  = 8'hF0;
        valid_i = 1'b1;
        #1;
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready_last got %b want 1", ready_o); end
      end
      n_cmp++; if (valid_o !== 1'b1 || data_o !== exp[k]) begin
        n_err++; $display("FAIL b2b_beat[%0d] got valid=%b data=%b want valid=1 data=%b", k, valid_o, data_o, exp[k]);
      end
      step();
      if (k == 7) begin
        valid_i = 1'b0;
        data_i  = 8'h00;
      end
    end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_done_valid got %b want 0", valid_o); end
  endtask

  task automatic test_midword_reset();
    logic [7:0] exp;
    load(8'b10000101);
    repeat (4) step();
    reset_i = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid got %b want 0", valid_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_ready got %b want 0", ready_o); end
    n_cmp++; if (data_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_data got %b want 0", data_o); end
    repeat (2) step();
    reset_i = 1'b1;
    step();
    n_cmp++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      n_err++; $display("FAIL mid_release got ready=%b valid=%b want ready=1 valid=0", ready_o, valid_o);
    end
    exp = 8'h3C;
    load(exp);
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (valid_o !== 1'b1 || data_o !== exp[k]) begin
        n_err++; $display("FAIL mid_after_beat[%0d] got valid=%b data=%b want valid=1 data=%b", k, valid_o, data_o, exp[k]);
      end
      step();
    end
  endtask

  // Serial-to-parallel reassembly under a stalling consumer.
  task automatic test_loopback();
    logic [7:0] rx;
    int beats;
    int cyc;
    rx = '0;
    beats = 0;
    cyc = 0;
    load(8'b10000101);
    while (beats < 8 && cyc < 60) begin
      ready_i = ((cyc % 3) != 2);
      #1;
      if (valid_o && ready_i) begin
        rx = {data_o, rx[7:1]};
        beats++;
      end
      step();
      cyc++;
    end
    ready_i = 1'b1;
    n_cmp++; if (beats !== 8) begin n_err++; $display("FAIL loop_beats got %0d want 8 (timeout)", beats); end
    n_cmp++; if (rx !== 8'b10000101) begin n_err++; $display("FAIL loop_word got %b want 10000101", rx); end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL loop_done_valid got %b want 0", valid_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_midword_reset();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
